// File: rtl/cpu_defs.sv
// Shared definitions for the EXE-stage HI/LO unit.
//   - Bit positions inside the one-hot hi_lo_op request vector.
//   - Controller state encoding.
//   - Divider iteration count and the width of the cycle counters.
package cpu_defs;

  // Bit positions inside hi_lo_op: {MTLO,MTHI,MFLO,MFHI,DIVU,DIV,MULTU,MULT}
  typedef enum int {
    HL_MULT  = 0,
    HL_MULTU = 1,
    HL_DIV   = 2,
    HL_DIVU  = 3,
    HL_MFHI  = 4,
    HL_MFLO  = 5,
    HL_MTHI  = 6,
    HL_MTLO  = 7
  } hi_lo_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } hi_lo_state_t;

  localparam int DIV_ITERS = 32;
  localparam int CNT_W     = 5;

  // Two's-complement magnitude; 0x8000_0000 maps onto itself, which is the
  // correct unsigned magnitude.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? 32'(-v) : v;
  endfunction

endpackage

// File: rtl/div_iter.sv
// One restoring-division step per cycle on a {remainder, quotient} pair.
// Ports:
//   clk, reset   - clock, asynchronous active-high reset
//   load_i       - preload: remainder=0, quotient=dividend, counter=31
//   step_i       - perform one step (MSB first) and decrement the counter
//   dividend_i   - unsigned dividend (magnitude for signed ops)
//   divisor_i    - unsigned divisor (magnitude for signed ops)
//   quo_next_o   - quotient after the step of the current cycle
//   rem_next_o   - remainder after the step of the current cycle
//   last_o       - counter is zero: the current step is the final one
module div_iter
  import cpu_defs::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic        step_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] quo_next_o,
  output logic [31:0] rem_next_o,
  output logic        last_o
);

  logic [31:0]      rem_q, quo_q, dvs_q;
  logic [CNT_W-1:0] cnt_q;
  logic [32:0]      shifted;
  logic             fits;

  // The quotient register doubles as the dividend shift register: its MSB
  // moves into the remainder each step and the new quotient bit enters at
  // the LSB.
  always_comb begin
    shifted    = {rem_q, quo_q[31]};
    fits       = (shifted >= {1'b0, dvs_q});
    rem_next_o = fits ? 32'(shifted - {1'b0, dvs_q}) : shifted[31:0];
    quo_next_o = {quo_q[30:0], fits};
  end

  assign last_o = (cnt_q == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      rem_q <= '0;
      quo_q <= dividend_i;
      dvs_q <= divisor_i;
      cnt_q <= CNT_W'(DIV_ITERS - 1);
    end else if (step_i) begin
      rem_q <= rem_next_o;
      quo_q <= quo_next_o;
      if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/hi_lo_unit.sv
// HI/LO responder for the EXE stage: owns HI and LO, runs a pipelined
// multiplier and a 32-step restoring divider, and reports completion.
// Ports:
//   clk, reset    - clock, asynchronous active-high reset
//   op_valid      - EXE holds a valid HI/LO instruction
//   hi_lo_op      - one-hot {MTLO,MTHI,MFLO,MFHI,DIVU,DIV,MULTU,MULT}
//   src1, src2    - rs / rt operand values
//   op_done       - EXE instruction leaves the stage this cycle
//   wr_disable    - squash: blocks HI/LO writes, aborts a busy operation
//   hi_lo_ready   - request complete, EXE may advance
//   hi_lo_result  - HI for MFHI, LO for MFLO, 0 otherwise
//   busy          - multiply or divide in progress
module hi_lo_unit
  import cpu_defs::*;
#(
  parameter int MUL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [7:0]  hi_lo_op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        op_done,
  input  logic        wr_disable,
  output logic        hi_lo_ready,
  output logic [31:0] hi_lo_result,
  output logic        busy
);

  hi_lo_state_t     state_q, state_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [CNT_W-1:0] mul_cnt_q;

  logic is_mul, is_div, is_mf, is_mt;
  logic accept_mul, accept_div, mul_final, div_final;

  assign is_mul = hi_lo_op[HL_MULT] | hi_lo_op[HL_MULTU];
  assign is_div = hi_lo_op[HL_DIV]  | hi_lo_op[HL_DIVU];
  assign is_mf  = hi_lo_op[HL_MFHI] | hi_lo_op[HL_MFLO];
  assign is_mt  = hi_lo_op[HL_MTHI] | hi_lo_op[HL_MTLO];

  assign accept_mul = (state_q == IDLE) && op_valid && is_mul && !wr_disable;
  assign accept_div = (state_q == IDLE) && op_valid && is_div && !wr_disable;

  // ---------------------------------------------------------------- multiply
  // Sign-extending both operands to 64 bits lets one 64x64->64 product serve
  // both MULT and MULTU. The product enters the chain on the accept edge and
  // reaches the last stage just before the final MUL edge.
  logic [63:0] mul_ext1, mul_ext2, mul_prod;
  logic [63:0] mul_pipe_q [MUL_CYCLES];

  always_comb begin
    mul_ext1 = {{32{hi_lo_op[HL_MULT] & src1[31]}}, src1};
    mul_ext2 = {{32{hi_lo_op[HL_MULT] & src2[31]}}, src2};
    mul_prod = mul_ext1 * mul_ext2;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MUL_CYCLES; i++) mul_pipe_q[i] <= '0;
    end else begin
      if (accept_mul) mul_pipe_q[0] <= mul_prod;
      for (int i = 1; i < MUL_CYCLES; i++) mul_pipe_q[i] <= mul_pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mul_cnt_q <= '0;
    end else if (accept_mul) begin
      mul_cnt_q <= CNT_W'(MUL_CYCLES - 1);
    end else if (state_q == MUL && mul_cnt_q != '0) begin
      mul_cnt_q <= mul_cnt_q - 1'b1;
    end
  end

  assign mul_final = (state_q == MUL) && (mul_cnt_q == '0) && !wr_disable;

  // ------------------------------------------------------------------ divide
  // The core divides magnitudes; sign handling and divide-by-zero are applied
  // on the write-back using flags captured at accept time.
  logic        div_signed;
  logic [31:0] div_quo, div_rem, div_lo, div_hi;
  logic        div_last;
  logic [31:0] dvd_raw_q;
  logic        quo_neg_q, rem_neg_q, div0_q;

  assign div_signed = hi_lo_op[HL_DIV];

  div_iter u_div_iter (
    .clk        (clk),
    .reset      (reset),
    .load_i     (accept_div),
    .step_i     (state_q == DIV),
    .dividend_i (div_signed ? abs32(src1) : src1),
    .divisor_i  (div_signed ? abs32(src2) : src2),
    .quo_next_o (div_quo),
    .rem_next_o (div_rem),
    .last_o     (div_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dvd_raw_q <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
    end else if (accept_div) begin
      dvd_raw_q <= src1;
      quo_neg_q <= div_signed & (src1[31] ^ src2[31]);
      rem_neg_q <= div_signed & src1[31];
      div0_q    <= (src2 == '0);
    end
  end

  always_comb begin
    if (div0_q) begin
      div_lo = 32'hFFFF_FFFF;
      div_hi = dvd_raw_q;
    end else begin
      div_lo = quo_neg_q ? 32'(-div_quo) : div_quo;
      div_hi = rem_neg_q ? 32'(-div_rem) : div_rem;
    end
  end

  assign div_final = (state_q == DIV) && div_last && !wr_disable;

  // ------------------------------------------------------------------ HI/LO
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (mul_final) begin
      {hi_d, lo_d} = mul_pipe_q[MUL_CYCLES-1];
    end else if (div_final) begin
      hi_d = div_hi;
      lo_d = div_lo;
    end else if (op_valid && op_done && !wr_disable) begin
      // op_done is a single-cycle pulse, so a stalled MT writes exactly once.
      if (hi_lo_op[HL_MTHI]) hi_d = src1;
      if (hi_lo_op[HL_MTLO]) lo_d = src1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  // -------------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept_mul)      state_d = MUL;
        else if (accept_div) state_d = DIV;
      end
      MUL: begin
        if (wr_disable)             state_d = IDLE;
        else if (mul_cnt_q == '0)   state_d = DONE;
      end
      DIV: begin
        if (wr_disable)    state_d = IDLE;
        else if (div_last) state_d = DONE;
      end
      DONE: begin
        if (op_done || wr_disable) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q == MUL) || (state_q == DIV);
    hi_lo_ready = !op_valid || is_mf || is_mt || (state_q == DONE);
    if (hi_lo_op[HL_MFHI])      hi_lo_result = hi_q;
    else if (hi_lo_op[HL_MFLO]) hi_lo_result = lo_q;
    else                        hi_lo_result = '0;
  end

  // EXE cannot retire a multiply/divide before ready, so op_done while busy
  // indicates a broken handshake upstream.
  a_no_done_while_busy : assert property (
    @(posedge clk) disable iff (reset) !(op_done && busy)
  );

endmodule

// File: tb/tb_hi_lo_unit.sv
module tb_hi_lo_unit;

  localparam logic [7:0] OP_MULT  = 8'h01;
  localparam logic [7:0] OP_MULTU = 8'h02;
  localparam logic [7:0] OP_DIV   = 8'h04;
  localparam logic [7:0] OP_DIVU  = 8'h08;
  localparam logic [7:0] OP_MFHI  = 8'h10;
  localparam logic [7:0] OP_MFLO  = 8'h20;
  localparam logic [7:0] OP_MTHI  = 8'h40;
  localparam logic [7:0] OP_MTLO  = 8'h80;

  logic        clk;
  logic        reset;
  logic        op_valid;
  logic [7:0]  hi_lo_op;
  logic [31:0] src1, src2;
  logic        op_done;
  logic        wr_disable;
  logic        hi_lo_ready;
  logic [31:0] hi_lo_result;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  hi_lo_unit #(.MUL_CYCLES(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .op_valid     (op_valid),
    .hi_lo_op     (hi_lo_op),
    .src1         (src1),
    .src2         (src2),
    .op_done      (op_done),
    .wr_disable   (wr_disable),
    .hi_lo_ready  (hi_lo_ready),
    .hi_lo_result (hi_lo_result),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic idle_inputs();
    op_valid   = 1'b0;
    hi_lo_op   = 8'h00;
    src1       = '0;
    src2       = '0;
    op_done    = 1'b0;
    wr_disable = 1'b0;
  endtask

  // Issue a MULT/DIV, measure cycles from the accept cycle to ready, hold one
  // extra cycle in DONE, then retire it with op_done.
  task automatic run_op(input string tag, input logic [7:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input int exp_lat);
    int n;
    op_valid = 1'b1;
    hi_lo_op = op;
    src1     = a;
    src2     = b;
    #1;
    check({tag, "_rdy0"}, 64'(hi_lo_ready), 64'(1'b0));
    step();
    n = 1;
    check({tag, "_busy"}, 64'(busy), 64'(1'b1));
    while (!hi_lo_ready && n < 100) begin
      step();
      n++;
    end
    check({tag, "_lat"}, 64'(n), 64'(exp_lat));
    step();
    check({tag, "_hold"}, 64'(hi_lo_ready), 64'(1'b1));
    op_done = 1'b1;
    step();
    idle_inputs();
  endtask

  task automatic read_hl(output logic [31:0] hi, output logic [31:0] lo);
    op_valid = 1'b1;
    hi_lo_op = OP_MFHI;
    op_done  = 1'b1;
    #1;
    hi = hi_lo_result;
    step();
    hi_lo_op = OP_MFLO;
    #1;
    lo = hi_lo_result;
    step();
    idle_inputs();
  endtask

  task automatic mt(input logic [7:0] op, input logic [31:0] v);
    op_valid = 1'b1;
    hi_lo_op = op;
    src1     = v;
    op_done  = 1'b1;
    step();
    idle_inputs();
  endtask

  logic [31:0] hi, lo;

  initial begin
    idle_inputs();
    reset    = 1'b1;
    op_valid = 1'b1;
    hi_lo_op = OP_MFHI;
    step();
    step();
    check("rst_mfhi", 64'(hi_lo_result), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    hi_lo_op = OP_MFLO;
    #1;
    check("rst_mflo", 64'(hi_lo_result), 64'h0);
    step();
    idle_inputs();
    reset = 1'b0;
    step();

    // MULT -2 * 3
    run_op("mult", OP_MULT, 32'hFFFF_FFFE, 32'd3, 3);
    read_hl(hi, lo);
    check("mult_hi", 64'(hi), 64'hFFFF_FFFF);
    check("mult_lo", 64'(lo), 64'hFFFF_FFFA);

    // DIVU 100 / 7
    run_op("divu", OP_DIVU, 32'd100, 32'd7, 33);
    read_hl(hi, lo);
    check("divu_hi", 64'(hi), 64'd2);
    check("divu_lo", 64'(lo), 64'd14);

    // DIV -7 / 2
    run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 33);
    read_hl(hi, lo);
    check("div_neg_hi", 64'(hi), 64'hFFFF_FFFF);
    check("div_neg_lo", 64'(lo), 64'hFFFF_FFFD);

    // DIV by zero
    run_op("div0", OP_DIV, 32'h0000_1234, 32'd0, 33);
    read_hl(hi, lo);
    check("div0_hi", 64'(hi), 64'h1234);
    check("div0_lo", 64'(lo), 64'hFFFF_FFFF);

    // Signed overflow 0x8000_0000 / -1
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33);
    read_hl(hi, lo);
    check("div_ovf_hi", 64'(hi), 64'h0);
    check("div_ovf_lo", 64'(lo), 64'h8000_0000);

    // Abort a DIVU with wr_disable
    mt(OP_MTHI, 32'h0000_AAAA);
    mt(OP_MTLO, 32'h0000_5555);
    op_valid = 1'b1;
    hi_lo_op = OP_DIVU;
    src1     = 32'd1000;
    src2     = 32'd3;
    for (int i = 0; i < 10; i++) step();
    wr_disable = 1'b1;
    #1;
    check("abort_busy_pre", 64'(busy), 64'h1);
    step();
    check("abort_busy", 64'(busy), 64'h0);
    idle_inputs();
    step();
    read_hl(hi, lo);
    check("abort_hi", 64'(hi), 64'hAAAA);
    check("abort_lo", 64'(lo), 64'h5555);

    // MTHI with EXE stalled four cycles
    op_valid = 1'b1;
    hi_lo_op = OP_MTHI;
    src1     = 32'h0000_DEAD;
    for (int i = 0; i < 4; i++) begin
      step();
      check("mthi_stall_rdy", 64'(hi_lo_ready), 64'h1);
    end
    op_done = 1'b1;
    step();
    idle_inputs();
    read_hl(hi, lo);
    check("mthi_hi", 64'(hi), 64'hDEAD);
    check("mthi_lo", 64'(lo), 64'h5555);

    // MTHI squashed on its op_done cycle
    op_valid = 1'b1;
    hi_lo_op = OP_MTHI;
    src1     = 32'h0000_BEEF;
    step();
    op_done    = 1'b1;
    wr_disable = 1'b1;
    step();
    idle_inputs();
    read_hl(hi, lo);
    check("mthi_sq_hi", 64'(hi), 64'hDEAD);

    // Reset in the middle of a DIVU
    op_valid = 1'b1;
    hi_lo_op = OP_DIVU;
    src1     = 32'd1000;
    src2     = 32'd3;
    for (int i = 0; i < 20; i++) step();
    check("rstdiv_busy_pre", 64'(busy), 64'h1);
    reset = 1'b1;
    #1;
    check("rstdiv_busy", 64'(busy), 64'h0);
    idle_inputs();
    step();
    reset = 1'b0;
    step();
    read_hl(hi, lo);
    check("rstdiv_hi", 64'(hi), 64'h0);
    check("rstdiv_lo", 64'(lo), 64'h0);

    // Fresh MULTU after reset
    run_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 3);
    read_hl(hi, lo);
    check("multu_hi", 64'(hi), 64'h1);
    check("multu_lo", 64'(lo), 64'hFFFF_FFFE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hi_lo_unit.md
Name: hi_lo_unit

Overview:
- Responder side of the EXE-stage HI/LO request interface.
- Accepts MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO requests from exe_stage and owns the architectural HI and LO registers.
- Runs a multi-cycle multiplier and a 32-iteration restoring divider, and signals completion with a ready flag that EXE folds into es_ready_go.
- Honours the pipeline's write-disable (exception/flush) so HI/LO never change for a squashed instruction.

Parameters:
- MUL_CYCLES, 2: cycles spent in MUL state; legal range 1..4.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- op_valid  in  1  EXE holds a valid instruction whose hi_lo_op is nonzero.
- hi_lo_op  in  8  one-hot {MTLO,MTHI,MFLO,MFHI,DIVU,DIV,MULTU,MULT}; held stable while op_valid.
- src1  in  32  rs value (dividend / multiplicand / MT source).
- src2  in  32  rt value (divisor / multiplier).
- op_done  in  1  pulse: the EXE instruction leaves the stage this cycle.
- wr_disable  in  1  squash: suppresses every HI/LO write and aborts a busy operation.
- hi_lo_ready  out  1  request complete; EXE may advance.
- hi_lo_result  out  32  MFHI returns HI, MFLO returns LO; 0 for all other ops.
- busy  out  1  state is MUL or DIV.

Behaviour:
- Reset (async): HI=0, LO=0, state=IDLE, cycle counter=0. hi_lo_result=0 and busy=0 while reset is held.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - op_valid & (MULT|MULTU) & !wr_disable: latch src1/src2, counter=MUL_CYCLES-1, go to MUL.
  - Same condition with DIV|DIVU: latch operands; divider is preloaded with abs values (signed) or raw values (unsigned); counter=31; go to DIV.
  - wr_disable high: stay in IDLE.
- MUL: decrement counter each cycle. At counter==0, write {HI,LO} = 64-bit product (signed or unsigned per op), then go to DONE.
- DIV: one restoring step per cycle, MSB first. At counter==0:
  - LO=quotient, HI=remainder, then go to DONE.
  - Signed sign-fix: quotient is negated iff operand signs differ; remainder takes the sign of the dividend.
- DONE: hi_lo_ready=1. Go to IDLE on op_done or wr_disable.
- Latency from the IDLE accept cycle to hi_lo_ready=1: DIV = 33 cycles; MUL = MUL_CYCLES+1 cycles. HI/LO update on the final busy-cycle edge.
- hi_lo_ready (combinational):
  - 1 when !op_valid.
  - 1 for MF*/MT* ops in any state.
  - For MULT/MULTU/DIV/DIVU: 1 only in DONE.
- MFHI/MFLO: hi_lo_result is the current HI/LO register value, no bypass. A preceding MUL/DIV has already committed before the MF instruction can enter EXE.
- MTHI/MTLO: write on the cycle op_done=1 & !wr_disable. Exactly one write per instruction even if EXE stalls.
- wr_disable:
  - In MUL or DIV: abort, return to IDLE next cycle, HI/LO unchanged.
  - Coincident with the final busy cycle: no write; go to IDLE.
- Divide by zero (either signedness): LO=32'hFFFF_FFFF, HI=src1, no sign-fix; still takes 33 cycles.
- 0x8000_0000 / -1 (signed): LO=0x8000_0000, HI=0.
- op_done while state is MUL or DIV is a protocol violation (EXE cannot advance without ready). It is ignored; add an assertion for it.
- Back-to-back identical DIVs: the second is accepted only after DONE→IDLE, i.e. one cycle after op_done.

Decomposition:
- cpu_defs package:
  - hi_lo_op_t bit indices (HL_MULT..HL_MTLO).
  - hi_lo_state_t enum {IDLE, MUL, DIV, DONE}.
  - DIV_ITERS=32.
- Sub-module div_iter: one restoring step on a {remainder, quotient} register pair, plus counter. Instantiated once.
- Multiplier: inferred `*` feeding a MUL_CYCLES-deep register chain.

Test Plan:
- MULT src1=0xFFFF_FFFE(-2), src2=3 -> ready after 3 cycles; HI=0xFFFF_FFFF, LO=0xFFFF_FFFA; MFLO then returns 0xFFFF_FFFA.
- DIVU 100/7 -> ready exactly 33 cycles after accept; LO=14, HI=2. DIV -7/2 -> LO=0xFFFF_FFFD, HI=0xFFFF_FFFF.
- DIV src2=0, src1=0x1234 -> LO=0xFFFF_FFFF, HI=0x1234. DIV 0x8000_0000/0xFFFF_FFFF -> LO=0x8000_0000, HI=0.
- Start DIVU, assert wr_disable at cycle 10 -> busy=0 next cycle; HI/LO keep prior values (0xAAAA/0x5555).
- MTHI 0xDEAD with EXE stalled 4 cycles, then op_done -> single write, HI=0xDEAD; repeat with wr_disable on the op_done cycle -> HI unchanged.
- Assert reset during DIV cycle 20 -> immediate IDLE, HI=LO=0, busy=0; a fresh MULTU 0xFFFF_FFFF*2 then yields HI=1, LO=0xFFFF_FFFE.
